// File: rtl/mdio_phy_slave.sv
// Clause-22 MDIO responder emulating a PHY register set (control, status,
// PHY-specific status). MDC/MDIO are oversampled on clk; bits are sampled on
// detected MDC rising edges and the pad is driven on detected falling edges.
module mdio_phy_slave #(
  parameter logic [4:0]  PHY_ADDR = 5'h01,
  parameter int          PRE_LEN  = 32,
  parameter logic [23:0] TIMEOUT  = 24'd100_000,
  parameter logic [15:0] CTRL_RST = 16'h1140
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        link_up,
  input  logic        an_done,
  input  logic [1:0]  speed_code,
  input  logic        full_duplex,
  output logic [15:0] ctrl_reg,
  output logic        soft_rst_pulse,
  output logic        frame_err
);

  localparam logic [5:0] PRE_LEN_C = 6'(PRE_LEN);

  typedef enum logic [2:0] {S_IDLE, S_ST2, S_OP, S_ADDR, S_TA, S_DATA} state_t;

  state_t      state, state_nxt;
  logic        mdc_s1, mdc_s2, mdc_d, mdio_s1, mdio_s2;
  logic        rise, fall;
  logic [5:0]  pre_cnt, pre_nxt;
  logic [4:0]  bit_cnt, bit_nxt;
  logic        is_read, rd_nxt;
  logic        op_first, opb_nxt;
  logic [9:0]  addr_sr, addr_nxt;
  logic [4:0]  reg_addr, reg_nxt;
  logic [15:0] shreg, sr_nxt;
  logic [23:0] to_cnt, to_nxt;
  logic        o_nxt, oe_nxt, soft_nxt, ferr_nxt, latch_nxt;
  logic [15:0] ctrl_nxt;
  logic        link_latch;
  logic [9:0]  addr_full;
  logic [15:0] wdata, rd_val;
  logic        latch_load, abort;

  assign rise = mdc_s2 & ~mdc_d;
  assign fall = ~mdc_s2 & mdc_d;

  // Two-flop synchronisers for MDC and MDIO, plus an MDC delay flop for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mdc_s1  <= 1'b0;
      mdc_s2  <= 1'b0;
      mdc_d   <= 1'b0;
      mdio_s1 <= 1'b0;
      mdio_s2 <= 1'b0;
    end else begin
      mdc_s1  <= mdc;
      mdc_s2  <= mdc_s1;
      mdc_d   <= mdc_s2;
      mdio_s1 <= mdio_i;
      mdio_s2 <= mdio_s1;
    end
  end

  // Frame decoder: next-state, datapath and output computation
  always_comb begin
    state_nxt  = state;
    pre_nxt    = pre_cnt;
    bit_nxt    = bit_cnt;
    rd_nxt     = is_read;
    opb_nxt    = op_first;
    addr_nxt   = addr_sr;
    reg_nxt    = reg_addr;
    sr_nxt     = shreg;
    o_nxt      = mdio_o;
    oe_nxt     = mdio_oe;
    ctrl_nxt   = ctrl_reg;
    soft_nxt   = 1'b0;
    ferr_nxt   = 1'b0;
    latch_load = 1'b0;
    addr_full  = {addr_sr[8:0], mdio_s2};
    wdata      = {shreg[14:0], mdio_s2};
    rd_val     = 16'h0000;

    case (addr_full[4:0])
      5'h00:   rd_val = ctrl_reg;
      5'h01: begin
        rd_val    = 16'h7949;
        rd_val[5] = an_done;
        rd_val[2] = link_latch;
      end
      5'h11:   rd_val = {speed_code, full_duplex, 1'b0, an_done, link_up, 10'b0};
      default: rd_val = 16'h0000;
    endcase

    if (state == S_IDLE) to_nxt = 24'd0;
    else if (rise)       to_nxt = 24'd0;
    else                 to_nxt = to_cnt + 24'd1;
    abort = (state != S_IDLE) && !rise && (to_cnt == TIMEOUT - 24'd1);

    if (abort) begin
      state_nxt = S_IDLE;
      pre_nxt   = 6'd0;
      oe_nxt    = 1'b0;
      o_nxt     = 1'b0;
      ferr_nxt  = 1'b1;
    end else begin
      case (state)
        S_IDLE: if (rise) begin
          if (mdio_s2) begin
            if (pre_cnt != 6'h3F) pre_nxt = pre_cnt + 6'd1;
          end else if (pre_cnt < PRE_LEN_C) begin
            pre_nxt = 6'd0;
          end else begin
            pre_nxt   = 6'd0;
            state_nxt = S_ST2;
          end
        end
        S_ST2: if (rise) begin
          bit_nxt = 5'd0;
          if (mdio_s2) state_nxt = S_OP;
          else begin
            ferr_nxt  = 1'b1;
            state_nxt = S_IDLE;
          end
        end
        S_OP: if (rise) begin
          if (bit_cnt == 5'd0) begin
            opb_nxt = mdio_s2;
            bit_nxt = 5'd1;
          end else begin
            bit_nxt = 5'd0;
            if ({op_first, mdio_s2} == 2'b10) begin
              rd_nxt    = 1'b1;
              state_nxt = S_ADDR;
            end else if ({op_first, mdio_s2} == 2'b01) begin
              rd_nxt    = 1'b0;
              state_nxt = S_ADDR;
            end else begin
              ferr_nxt  = 1'b1;
              state_nxt = S_IDLE;
            end
          end
        end
        S_ADDR: if (rise) begin
          addr_nxt = addr_full;
          if (bit_cnt == 5'd9) begin
            bit_nxt = 5'd0;
            if (addr_full[9:5] != PHY_ADDR) state_nxt = S_IDLE;
            else begin
              reg_nxt   = addr_full[4:0];
              state_nxt = S_TA;
              if (is_read) sr_nxt = rd_val;
            end
          end else begin
            bit_nxt = bit_cnt + 5'd1;
          end
        end
        S_TA: begin
          if (is_read) begin
            if (rise) begin
              if (bit_cnt == 5'd0) bit_nxt = 5'd1;
              else begin
                bit_nxt   = 5'd0;
                state_nxt = S_DATA;
              end
            end else if (fall && bit_cnt == 5'd1) begin
              oe_nxt = 1'b1;
              o_nxt  = 1'b0;
            end
          end else if (rise) begin
            if (mdio_s2 == (bit_cnt == 5'd0)) begin
              if (bit_cnt == 5'd0) bit_nxt = 5'd1;
              else begin
                bit_nxt   = 5'd0;
                state_nxt = S_DATA;
              end
            end else begin
              ferr_nxt  = 1'b1;
              state_nxt = S_IDLE;
            end
          end
        end
        S_DATA: begin
          if (is_read) begin
            if (fall) begin
              if (bit_cnt == 5'd16) begin
                oe_nxt    = 1'b0;
                o_nxt     = 1'b0;
                state_nxt = S_IDLE;
              end else begin
                o_nxt  = shreg[15];
                sr_nxt = {shreg[14:0], 1'b0};
              end
            end else if (rise && bit_cnt != 5'd16) begin
              bit_nxt = bit_cnt + 5'd1;
              if (bit_cnt == 5'd15 && reg_addr == 5'h01) latch_load = 1'b1;
            end
          end else if (rise) begin
            sr_nxt = wdata;
            if (bit_cnt == 5'd15) begin
              state_nxt = S_IDLE;
              if (reg_addr == 5'h00) begin
                if (wdata[15]) begin
                  ctrl_nxt = CTRL_RST;
                  soft_nxt = 1'b1;
                end else begin
                  ctrl_nxt = wdata;
                end
              end
            end else begin
              bit_nxt = bit_cnt + 5'd1;
            end
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end

    if (!link_up)        latch_nxt = 1'b0;
    else if (latch_load) latch_nxt = 1'b1;
    else                 latch_nxt = link_latch;
  end

  // State and datapath registers; reset releases the pad immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      pre_cnt        <= 6'd0;
      bit_cnt        <= 5'd0;
      is_read        <= 1'b0;
      op_first       <= 1'b0;
      addr_sr        <= 10'd0;
      reg_addr       <= 5'd0;
      shreg          <= 16'd0;
      to_cnt         <= 24'd0;
      mdio_o         <= 1'b0;
      mdio_oe        <= 1'b0;
      ctrl_reg       <= CTRL_RST;
      soft_rst_pulse <= 1'b0;
      frame_err      <= 1'b0;
      link_latch     <= 1'b0;
    end else begin
      state          <= state_nxt;
      pre_cnt        <= pre_nxt;
      bit_cnt        <= bit_nxt;
      is_read        <= rd_nxt;
      op_first       <= opb_nxt;
      addr_sr        <= addr_nxt;
      reg_addr       <= reg_nxt;
      shreg          <= sr_nxt;
      to_cnt         <= to_nxt;
      mdio_o         <= o_nxt;
      mdio_oe        <= oe_nxt;
      ctrl_reg       <= ctrl_nxt;
      soft_rst_pulse <= soft_nxt;
      frame_err      <= ferr_nxt;
      link_latch     <= latch_nxt;
    end
  end

endmodule
